// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle for mem_access_unit.
// master = requester (execute stage), slave = mem_access_unit.
interface mem_access_unit_if #(
  parameter int RAM_AW = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [RAM_AW+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-only synchronous RAM.
// Latency: err 1, word store 2, load 3, sub-word store (RMW) 4 cycles; one request in flight, no resp back-pressure.
module mem_access_unit #(
  parameter int   RAM_AW    = 8,
  parameter int   DW        = 32,
  parameter logic RAM_READ  = 1'b0,
  parameter logic RAM_WRITE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus,
  output logic              o_ram_en,
  output logic              o_ram_wr,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [DW-1:0]     o_ram_din,
  input  logic [DW-1:0]     i_ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [1:0]        r_off;
  logic [15:0]       r_wdata;
  logic              r_ram_en;
  logic              r_ram_wr;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [DW-1:0]     r_ram_din;
  logic              r_resp_valid;
  logic [DW-1:0]     r_resp_rdata;
  logic              r_resp_err;

  logic              w_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DW-1:0]     w_load;
  logic [DW-1:0]     w_merged;

  assign w_err = (bus.req_size == 2'd3) ||
                 (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                 (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);

  // Lane extraction for loads and lane replacement for RMW stores share the captured offset.
  always_comb begin
    w_byte   = 8'(i_ram_dout >> {r_off, 3'b000});
    w_half   = r_off[1] ? i_ram_dout[31:16] : i_ram_dout[15:0];
    w_load   = i_ram_dout;
    w_merged = i_ram_dout;
    case (r_size)
      2'd0: begin
        w_load = {{24{r_sign & w_byte[7]}}, w_byte};
        w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'd1: begin
        w_load = {{16{r_sign & w_half[15]}}, w_half};
        w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_sign       <= 1'b0;
      r_off        <= 2'd0;
      r_wdata      <= '0;
      r_ram_en     <= 1'b0;
      r_ram_wr     <= RAM_READ;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_ram_en     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_sign     <= bus.req_sign;
            r_off      <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata[15:0];
            r_ram_addr <= bus.req_addr[RAM_AW+1:2];
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_state      <= S_RESP;
            end else if (bus.req_we && bus.req_size == 2'd2) begin
              r_ram_en  <= 1'b1;
              r_ram_wr  <= RAM_WRITE;
              r_ram_din <= bus.req_wdata;
              r_state   <= S_WR_ISSUE;
            end else begin
              r_ram_en <= 1'b1;
              r_ram_wr <= RAM_READ;
              r_state  <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (r_we) begin
            r_ram_din <= w_merged;
            r_ram_en  <= 1'b1;
            r_ram_wr  <= RAM_WRITE;
            r_state   <= S_WR_ISSUE;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
            r_state      <= S_RESP;
          end
        end
        S_WR_ISSUE: begin
          r_ram_wr     <= RAM_READ;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE) && reset;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign o_ram_en       = r_ram_en;
  assign o_ram_wr       = r_ram_wr;
  assign o_ram_addr     = r_ram_addr;
  assign o_ram_din      = r_ram_din;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a word RAM model and an arithmetic reference memory.
module tb_mem_access_unit;
  localparam int AW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  mem_access_unit_if #(.RAM_AW(AW)) bus ();

  logic          ram_en;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = '0;

  mem_access_unit #(.RAM_AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .o_ram_en  (ram_en),
    .o_ram_wr  (ram_wr),
    .o_ram_addr(ram_addr),
    .o_ram_din (ram_din),
    .i_ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // Synchronous word RAM: read data appears the cycle after the read edge.
  logic [31:0] ram_mem [256];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_wr) ram_mem[ram_addr] <= ram_din;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          n_en;
    logic        has_wr;
    logic [7:0]  waddr;
    logic [31:0] wdat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [9:0] addr, input logic [31:0] wdata, input bit commit);
    exp_t        e;
    int          w;
    int          sh;
    logic [31:0] old;
    logic [31:0] v;
    int          k;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_sign  = sign;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    if (k == 50) begin
      $display("FAIL req_accept_timeout: req_ready never rose (cycle %0d)", cyc);
      $fatal(1);
    end
    w        = int'(addr[9:2]);
    old      = ref_mem[w];
    e.err    = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    e.rdata  = '0;
    e.waddr  = addr[9:2];
    e.has_wr = 1'b0;
    e.wdat   = '0;
    if (e.err) begin
      e.lat = 1; e.n_en = 0;
    end else if (we) begin
      e.has_wr = 1'b1;
      if (size == 2'd2) begin
        v = wdata; e.lat = 2; e.n_en = 1;
      end else begin
        sh = (size == 2'd0) ? int'(addr[1:0]) * 8 : int'(addr[1]) * 16;
        v  = (size == 2'd0) ? ((old & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh))
                            : ((old & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh));
        e.lat = 4; e.n_en = 2;
      end
      e.wdat = v;
      if (commit) ref_mem[w] = v;
    end else begin
      e.lat = 3; e.n_en = 1;
      if (size == 2'd0) begin
        v = (old >> (int'(addr[1:0]) * 8)) & 32'hFF;
        if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        v = (old >> (int'(addr[1]) * 16)) & 32'hFFFF;
        if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
        v = old;
      end
      e.rdata = v;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    exp_q.push_back(e);
    // Scramble the request lines while busy; the unit must use its captured copy.
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_size  = 2'($urandom);
    bus.req_sign  = 1'($urandom);
    bus.req_addr  = 10'($urandom);
    bus.req_wdata = $urandom;
  endtask

  // Monitor: reset values, handshake, RAM cycles and responses against the scoreboard.
  logic prev_en   = 1'b0;
  logic prev_resp = 1'b0;
  logic was_rst   = 1'b0;
  int   en_cnt    = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_wr", ram_wr, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_resp_err", bus.resp_err, 0);
      exp_q.delete();
      en_cnt = 0; prev_en = 1'b0; prev_resp = 1'b0; was_rst = 1'b1;
    end else begin
      if (was_rst) chk("ready_after_reset", bus.req_ready, 1);
      if (prev_resp) chk("ready_after_resp", bus.req_ready, 1);
      was_rst = 1'b0;
      if (exp_q.size() > 0) chk("ready_while_busy", bus.req_ready, 0);
      if (ram_en) begin
        if (prev_en) chk("ram_en_consecutive", ram_en, 0);
        if (exp_q.size() == 0) chk("ram_en_when_idle", ram_en, 0);
        else begin
          e = exp_q[0];
          chk("ram_addr", ram_addr, e.waddr);
          chk("ram_wr", ram_wr, (e.has_wr && en_cnt == e.n_en - 1) ? 1 : 0);
          if (ram_wr) chk("ram_din", ram_din, e.wdat);
        end
        en_cnt++;
      end
      prev_en   = ram_en;
      prev_resp = bus.resp_valid;
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) chk("resp_unexpected", bus.resp_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", bus.resp_err, e.err);
          chk("resp_latency", cyc - e.acc + 1, e.lat);
          chk("ram_en_count", en_cnt, e.n_en);
        end
        en_cnt = 0;
      end
    end
  end

  initial begin
    logic [1:0] sz;
    logic [9:0] ad;
    int         k;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_sign  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    issue(1, 2'd2, 0, 10'h008, 32'h1234_5678, 1);
    issue(0, 2'd2, 0, 10'h008, 32'h0, 1);
    issue(1, 2'd0, 0, 10'h00A, 32'hFFFF_FFAB, 1);
    issue(0, 2'd0, 1, 10'h00A, 32'h0, 1);
    issue(0, 2'd0, 0, 10'h00A, 32'h0, 1);
    issue(0, 2'd1, 1, 10'h00A, 32'h0, 1);
    issue(0, 2'd1, 0, 10'h009, 32'h0, 1);
    issue(0, 2'd3, 0, 10'h008, 32'h0, 1);
    issue(1, 2'd2, 0, 10'h00A, 32'hDEAD_BEEF, 1);

    // Abort a byte RMW in RD_WAIT; word 2 must keep its old value.
    issue(1, 2'd0, 0, 10'h008, 32'h0000_00CD, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    issue(0, 2'd2, 0, 10'h008, 32'h0, 1);

    issue(1, 2'd2, 0, 10'h3FC, 32'hCAFE_F00D, 1);
    issue(0, 2'd2, 0, 10'h3FC, 32'h0, 1);
    issue(0, 2'd2, 0, 10'h008, 32'h0, 1);
    issue(1, 2'd0, 0, 10'h3FF, 32'h0000_0077, 1);
    issue(0, 2'd1, 1, 10'h3FE, 32'h0, 1);

    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'd0;
      end
      issue(1'($urandom), sz, 1'($urandom), ad, $urandom, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (k == 100) begin
      $display("FAIL drain_timeout: %0d responses still outstanding", exp_q.size());
      $fatal(1);
    end
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
